// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V datapath.
// Used by fetch_unit and the decode-side controller.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem request/response,
// one-deep instruction hold toward decode, branch redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         kill, kill_n;
  logic [31:0]  inst_n, inst_pc_n, count_n;
  logic [31:0]  target;

  assign target     = redirect_pc & ~32'd3;
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == S_HOLD);
  assign opcode     = inst[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      inst        <= NOP_INSTR;
      inst_pc     <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      kill        <= kill_n;
      inst        <= inst_n;
      inst_pc     <= inst_pc_n;
      fetch_count <= count_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    kill_n    = kill;
    inst_n    = inst;
    inst_pc_n = inst_pc;
    count_n   = fetch_count;
    unique case (state)
      S_REQ: begin
        if (imem_ready) begin
          state_n = S_WAIT;
          kill_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // a redirect in the return cycle kills this word too
          if (kill || redirect_valid) begin
            state_n = S_REQ;
            kill_n  = 1'b0;
          end else begin
            inst_n    = imem_rdata;
            inst_pc_n = pc;
            state_n   = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          count_n = fetch_count + 32'd1;
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
        if (redirect_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
    if (redirect_valid) pc_n = target;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against
// a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int n_chk = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A3C_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  logic [31:0] exp_pc, exp_cnt, paddr, pinst, ppc, addr_now;
  logic        pend, pstall, acc, hs, rv_now, redir;
  logic [31:0] tgt;
  int          lat;

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    rst = 1'b0;

    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    chk("wait_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    cyc();
    imem_rvalid = 1'b0;
    chk("c3_valid", {31'b0, inst_valid}, 32'd1);
    chk("c3_pc", inst_pc, RPC);
    chk("c3_op", {25'b0, opcode}, 32'h13);
    chk("c3_inst", inst, 32'h00A0_0093);

    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_inst", inst, 32'h00A0_0093);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_cnt", fetch_count, 32'd0);
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("hs_cnt", fetch_count, 32'd1);
    chk("hs_req", {31'b0, imem_req}, 32'd1);
    chk("hs_addr", imem_addr, 32'h104);

    // redirect while waiting on a 3-cycle response
    imem_ready = 1'b1;
    cyc();
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    chk("rw_valid1", {31'b0, inst_valid}, 32'd0);
    cyc();
    chk("rw_valid2", {31'b0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    chk("rw_valid3", {31'b0, inst_valid}, 32'd0);
    chk("rw_req", {31'b0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h200);

    imem_ready = 1'b1;
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    cyc();
    imem_rvalid = 1'b0;
    chk("f200_pc", inst_pc, 32'h200);
    chk("f200_op", {25'b0, opcode}, 32'h33);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h302;
    inst_ready     = 1'b1;
    cyc();
    idle();
    chk("rh_cnt", fetch_count, 32'd2);
    chk("rh_addr", imem_addr, 32'h300);
    chk("rh_req", {31'b0, imem_req}, 32'd1);

    // redirect coincident with request acceptance
    imem_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cyc();
    idle();
    chk("ra_req", {31'b0, imem_req}, 32'd0);
    chk("ra_addr", imem_addr, 32'h400);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0;
    chk("ra_valid", {31'b0, inst_valid}, 32'd0);
    chk("ra_req2", {31'b0, imem_req}, 32'd1);
    chk("ra_addr2", imem_addr, 32'h400);

    // reset while waiting
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rr_req", {31'b0, imem_req}, 32'd1);
    chk("rr_addr", imem_addr, RPC);
    chk("rr_cnt", fetch_count, 32'd0);
    chk("rr_valid", {31'b0, inst_valid}, 32'd0);

    // randomized traffic against the fetch-stream model
    exp_pc  = RPC;
    exp_cnt = 32'd0;
    pend    = 1'b0;
    paddr   = 32'h0;
    lat     = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("r_addr", imem_addr, exp_pc);
      chk("r_cnt", fetch_count, exp_cnt);
      if (pend) begin
        chk("r_one_out", {30'b0, imem_req, inst_valid}, 32'd0);
      end

      idle();
      rst        = ($urandom_range(0, 299) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ?
                       32'hFFFF_FFFE : $urandom;
      imem_rdata = $urandom;
      rv_now     = 1'b0;
      if (pend) begin
        lat--;
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem(paddr);
          rv_now      = 1'b1;
        end
      end else if ((imem_req || inst_valid) &&
                   $urandom_range(0, 5) == 0) begin
        imem_rvalid = 1'b1;
      end

      acc      = imem_req && imem_ready;
      hs       = inst_valid && inst_ready;
      redir    = redirect_valid;
      tgt      = redirect_pc & ~32'd3;
      addr_now = imem_addr;
      pstall   = inst_valid && !inst_ready && !redir && !rst;
      pinst    = inst;
      ppc      = inst_pc;
      if (hs) begin
        chk("r_hs_pc", inst_pc, exp_pc);
        chk("r_hs_inst", inst, mem(exp_pc));
        chk("r_hs_op", {25'b0, opcode}, {25'b0, mem(exp_pc) & 32'h7F});
      end

      cyc();

      if (rst) begin
        exp_pc  = RPC;
        exp_cnt = 32'd0;
        pend    = 1'b0;
      end else begin
        if (hs) exp_cnt = exp_cnt + 32'd1;
        if (redir) exp_pc = tgt;
        else if (hs) exp_pc = exp_pc + 32'd4;
        if (rv_now) pend = 1'b0;
        if (acc) begin
          pend  = 1'b1;
          paddr = addr_now;
          lat   = $urandom_range(1, 3);
        end
      end
      if (pstall) begin
        chk("r_hold_valid", {31'b0, inst_valid}, 32'd1);
        chk("r_hold_inst", inst, pinst);
        chk("r_hold_pc", inst_pc, ppc);
      end
    end
    idle();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
